seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Consumer end of the logic block's `data_o` / `layout_o` result interface.
- Converts a 32-bit value and a 4-bit layout code into a multiplexed, active-low 8-digit seven-segment drive.
- Supports hex or decimal rendering, leading-zero suppression and full blanking.
- Sits between the logic core and the board display pins.

Parameters:
- SCAN_DIV, 100000: clk cycles each digit stays active (must be >= 2).
- DIGITS, 8: number of digits scanned; fixed at 8 in this revision.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- data_i  in  32  value to display, unsigned.
- layout_i  in  4  display mode:
  - [1:0]: 0 = hex, 1 = decimal, 2/3 = hex.
  - [2]: leading-zero suppression.
  - [3]: blank.
- an_o  out  8  digit anodes, active-low; bit 0 = rightmost digit (least significant).
- seg_o  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp_o  out  1  decimal point, active-low; held 1 (off).

Behaviour:
- Reset: the following are cleared asynchronously and immediately:
  - Outputs: an_o=8'hFF, seg_o=7'h7F, dp_o=1.
  - Internal state: prescaler=0, digit index=0, snapshot regs=0, display nibble regs=0, overflow flag=0, FSM=IDLE.
- Reset mid-conversion aborts the conversion. The display shows 0 after release.
- Input capture FSM states: IDLE, CONV, COMMIT.
  - IDLE: latch data_i/layout_i into the snapshot every cycle.
    - Decimal: go to CONV.
    - Hex: go to COMMIT.
  - CONV: sequential shift-add-3 (double dabble), exactly 32 cycles, producing 10 BCD digits. Inputs are ignored while in CONV.
  - COMMIT: atomically load the 8 display nibbles, overflow flag and layout flags; return to IDLE.
- Input-to-display latency:
  - Hex: 2 clk.
  - Decimal: 34 clk (1 capture + 32 conversion + 1 commit).
- During CONV the previously committed image keeps displaying; no partial values are ever shown.
- Decimal overflow: if either of BCD digits 9/8 is non-zero (value > 99_999_999), the overflow flag is set and all 8 digits show dash (7'b0111111).
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. On wrap, the digit index increments modulo 8 (7 -> 0).
  - an_o and seg_o are registered and change 1 clk after the index changes.
  - Exactly one an_o bit is low at any time, unless blanked.
- Glyphs: hex 0-F in standard encoding, e.g. 0=7'b1000000, 1=7'b1111001, A=7'b0001000, D=7'b0100001.
- Leading-zero suppression (layout[2]=1):
  - Digits above the most significant non-zero digit drive seg_o=7'h7F; their anode is still scanned.
  - Digit 0 is always shown, so a value of 0 shows "0".
  - Ignored when the overflow flag is set.
- Blank (layout[3]=1, committed): an_o=8'hFF, seg_o=7'h7F. Scanning continues internally.
- Layout changes take effect only via COMMIT, with the same latency rules as data.

Optional Feature:
- Macro: SEG7_DEC_EN.
- Defined: decimal mode, bin2bcd_seq instance and CONV state are present, as described above.
- Undefined:
  - layout[1:0]=1 is treated as hex; the FSM always goes IDLE->COMMIT; no overflow flag exists.
  - Latency is 2 clk for all modes.

Decomposition:
- Package seg7_pkg:
  - FMT_HEX/FMT_DEC constants.
  - GLYPH_DASH (7'b0111111) and GLYPH_BLANK (7'h7F).
  - hex-to-glyph function.
  - FSM state typedef (IDLE/CONV/COMMIT).
- Sub-module bin2bcd_seq:
  - Ports: start/busy/done handshake, 32-bit in, 40-bit BCD out.
  - Takes 32 cycles from start to done.
  - Only compiled under SEG7_DEC_EN.

Test Plan:
1. Async reset: SCAN_DIV=4, assert rst_i between clock edges -> an_o=8'hFF, seg_o=7'h7F before the next edge; after release digit 0 shows "0".
2. Hex scan: SCAN_DIV=4, data_i=32'h1234ABCD, layout_i=0 -> over one 32-cycle frame:
   - an_o walks FE,FD,...,7F.
   - seg_o shows D,C,B,A,4,3,2,1 (digit 0 = 7'b0100001, digit 7 = 7'b1111001).
3. Decimal: data_i=12345678, layout_i=1 -> old image held for 33 clk; from clk 34 the digits read 1..8 MSD->LSD.
4. Decimal overflow: data_i=100_000_000, layout_i=1 -> all 8 digits 7'b0111111. Then data_i=99_999_999 -> all digits "9".
5. Leading-zero suppression: data_i=32'hA5, layout_i=4'b0100 -> digits 7..2 seg_o=7'h7F with anodes still scanned; digits 1,0 show A,5. Then data_i=0 -> digit 0 shows "0".
6. Blank: layout_i=4'b1000 with any data -> an_o=8'hFF from 2 clk later. Clearing layout_i[3] restores scanning at the current digit index.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared format codes, glyphs, hex glyph lookup and capture FSM states for seg7_scan_driver
package seg7_pkg;
  localparam logic [1:0] FMT_HEX = 2'd0;
  localparam logic [1:0] FMT_DEC = 2'd1;
  localparam logic [6:0] GLYPH_DASH = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    hex_glyph = GLYPH_BLANK;
    case (n)
      4'h0: hex_glyph = 7'b1000000;
      4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;
      4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;
      4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;
      4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;
      4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;
      4'hF: hex_glyph = 7'b0001110;
      default: hex_glyph = GLYPH_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 32-cycle shift-add-3 binary to 10-digit BCD converter, compiled only with SEG7_DEC_EN
`ifdef SEG7_DEC_EN
module bin2bcd_seq (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] bin_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [39:0] bcd_o
);
  logic [39:0] bcd_q, bcd_d;
  logic [35:0] adj;
  logic [31:0] bin_q, bin_d, src;
  logic [4:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d;
  // one double-dabble step per cycle; start performs the first step on a cleared BCD register
  // the top digit never exceeds 4 for a 32-bit input, so it needs no add-3 correction
  always_comb begin
    src = start_i ? bin_i : bin_q;
    for (int i = 0; i < 9; i++)
      adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    bcd_d = bcd_q;
    bin_d = bin_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i || busy_q) begin
      bcd_d = start_i ? {39'd0, src[31]} : {bcd_q[38:36], adj, src[31]};
      bin_d = {src[30:0], 1'b0};
      cnt_d = start_i ? 5'd1 : cnt_q + 5'd1;
      busy_d = start_i || cnt_q != 5'd31;
      done_d = !start_i && cnt_q == 5'd31;
    end
  end
  // conversion state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bcd_q <= '0; bin_q <= '0; cnt_q <= '0; busy_q <= 1'b0; done_q <= 1'b0;
    end else begin
      bcd_q <= bcd_d; bin_q <= bin_d; cnt_q <= cnt_d; busy_q <= busy_d; done_q <= done_d;
    end
  end
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o = bcd_q;
endmodule
`endif

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed active-low 8-digit seven-segment driver; define SEG7_DEC_EN for decimal mode
module seg7_scan_driver #(
  parameter int SCAN_DIV = 100000,
  parameter int DIGITS = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       data_i,
  input  logic [3:0]        layout_i,
  output logic [DIGITS-1:0] an_o,
  output logic [6:0]        seg_o,
  output logic              dp_o
);
  import seg7_pkg::*;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  state_t state_q, state_d;
  logic [31:0] data_q, data_d, nib_q, nib_d, sig;
  logic [1:0] lay_q, lay_d;
  logic lz_q, lz_d, blank_q, blank_d, ovf_d, wrap;
  logic [PW-1:0] pre_q, pre_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
`ifdef SEG7_DEC_EN
  logic ovf_q, dec_q, dec_d, start, busy, done;
  logic [39:0] bcd;
  bin2bcd_seq u_bcd (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start),
    .bin_i   (data_i),
    .busy_o  (busy),
    .done_o  (done),
    .bcd_o   (bcd)
  );
`else
  logic unused_fmt;
  assign ovf_d = 1'b0;
  assign unused_fmt = ^layout_i[1:0];
`endif
  // capture inputs in IDLE, wait out the converter in CONV, swap the whole display image in COMMIT
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    lay_d = lay_q;
    nib_d = nib_q;
    lz_d = lz_q;
    blank_d = blank_q;
`ifdef SEG7_DEC_EN
    dec_d = dec_q;
    ovf_d = ovf_q;
    start = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        data_d = data_i;
        lay_d = layout_i[3:2];
`ifdef SEG7_DEC_EN
        dec_d = layout_i[1:0] == FMT_DEC;
        start = dec_d;
        state_d = dec_d ? CONV : COMMIT;
`else
        state_d = COMMIT;
`endif
      end
`ifdef SEG7_DEC_EN
      CONV: state_d = done ? COMMIT : (busy ? CONV : IDLE);
`endif
      COMMIT: begin
        {blank_d, lz_d} = lay_q;
`ifdef SEG7_DEC_EN
        nib_d = dec_q ? bcd[31:0] : data_q;
        ovf_d = dec_q && bcd[39:32] != 8'd0;
`else
        nib_d = data_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // capture/commit registers; reset leaves a zero hex image
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE; data_q <= '0; lay_q <= '0; nib_q <= '0; lz_q <= 1'b0; blank_q <= 1'b0;
`ifdef SEG7_DEC_EN
      dec_q <= 1'b0; ovf_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d; data_q <= data_d; lay_q <= lay_d; nib_q <= nib_d; lz_q <= lz_d; blank_q <= blank_d;
`ifdef SEG7_DEC_EN
      dec_q <= dec_d; ovf_q <= ovf_d;
`endif
    end
  end
  // prescaler and digit index; next pattern for the current digit from the image being committed this cycle
  always_comb begin
    wrap = pre_q == PW'(SCAN_DIV - 1);
    pre_d = wrap ? '0 : pre_q + PW'(1);
    idx_d = wrap ? idx_q + IW'(1) : idx_q;
    sig = nib_d >> {idx_q, 2'b00};
    an_d = blank_d ? '1 : ~(DIGITS'(1) << idx_q);
    seg_d = blank_d ? GLYPH_BLANK : ovf_d ? GLYPH_DASH :
            (lz_d && idx_q != '0 && sig == 32'd0) ? GLYPH_BLANK : hex_glyph(sig[3:0]);
  end
  // scan counters and registered display outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_q <= '0; idx_q <= '0; an_q <= '1; seg_q <= GLYPH_BLANK;
    end else begin
      pre_q <= pre_d; idx_q <= idx_d; an_q <= an_d; seg_q <= seg_d;
    end
  end
  assign an_o = an_q;
  assign seg_o = seg_q;
  assign dp_o = 1'b1;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized self-checking bench against a digit-level display model
`timescale 1ns/1ps
module tb_seg7_scan_driver;
  localparam int SD = 4;
`ifdef SEG7_DEC_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [31:0] data_i = '0;
  logic [3:0] layout_i = '0;
  logic [7:0] an_o;
  logic [6:0] seg_o;
  logic dp_o;
  int vecs = 0;
  int errs = 0;
  seg7_scan_driver #(.SCAN_DIV(SD), .DIGITS(8)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .data_i   (data_i),
    .layout_i (layout_i),
    .an_o     (an_o),
    .seg_o    (seg_o),
    .dp_o     (dp_o)
  );
  always #5 clk_i = ~clk_i;
  logic [6:0] gl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] img [8];
  logic img_blank;
  logic [7:0] exp_an = 8'hFF;
  logic [6:0] exp_seg = 7'h7F;
  int e, next_cap, commit_at;
  logic [31:0] cap_v;
  logic [3:0] cap_l;
  task automatic render(input logic [31:0] v, input logic [3:0] l);
    bit dec, ovf;
    int d [8];
    int msd;
    int unsigned p;
    dec = DEC_EN && l[1:0] == 2'd1;
    ovf = dec && v > 32'd99_999_999;
    p = 1;
    msd = 0;
    for (int i = 0; i < 8; i++) begin
      d[i] = dec ? int'((v / p) % 10) : int'((v >> (4 * i)) & 32'hF);
      p = p * 10;
      if (d[i] != 0) msd = i;
    end
    for (int i = 0; i < 8; i++)
      img[i] = ovf ? 7'b0111111 : (l[2] && i > msd) ? 7'h7F : gl[d[i]];
    img_blank = l[3];
  endtask
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e = 0;
      next_cap = 1;
      commit_at = -1;
      render(32'd0, 4'd0);
      exp_an = 8'hFF;
      exp_seg = 7'h7F;
    end else begin
      e = e + 1;
      if (e == commit_at) begin
        render(cap_v, cap_l);
        next_cap = e + 1;
      end
      if (e == next_cap) begin
        cap_v = data_i;
        cap_l = layout_i;
        commit_at = e + ((DEC_EN && layout_i[1:0] == 2'd1) ? 33 : 1);
      end
      exp_an = img_blank ? 8'hFF : ~(8'd1 << (((e - 1) / SD) % 8));
      exp_seg = img_blank ? 7'h7F : img[((e - 1) / SD) % 8];
    end
  end
  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    vecs++;
    if ({an_o, seg_o, dp_o} !== {8'hFF, 7'h7F, 1'b1}) begin
      errs++;
      $display("FAIL reset_hold an=%h seg=%h dp=%b expected an=ff seg=7f dp=1", an_o, seg_o, dp_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    vecs++;
    if ({an_o, seg_o} !== {8'hFE, 7'b1000000}) begin
      errs++;
      $display("FAIL reset_release an=%h seg=%h expected an=fe seg=40", an_o, seg_o);
    end
    data_i = 32'h0000_0F3C;
    repeat (40) begin
      @(negedge clk_i);
      vecs++;
      if ({an_o, seg_o, dp_o} !== {exp_an, exp_seg, 1'b1}) begin
        errs++;
        $display("FAIL reset_run t=%0t an=%h seg=%h dp=%b expected an=%h seg=%h", $time, an_o, seg_o, dp_o, exp_an, exp_seg);
      end
    end
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    vecs++;
    if ({an_o, seg_o} !== {8'hFF, 7'h7F}) begin
      errs++;
      $display("FAIL async_reset an=%h seg=%h expected an=ff seg=7f", an_o, seg_o);
    end
    @(negedge clk_i);
    data_i = '0;
    rst_i = 1'b0;
    repeat (12) begin
      @(negedge clk_i);
      vecs++;
      if ({an_o, seg_o, dp_o} !== {exp_an, exp_seg, 1'b1}) begin
        errs++;
        $display("FAIL reset_after t=%0t an=%h seg=%h dp=%b expected an=%h seg=%h", $time, an_o, seg_o, dp_o, exp_an, exp_seg);
      end
    end
  endtask
  task automatic test_hex_scan();
    data_i = 32'h1234_ABCD;
    layout_i = 4'h0;
    repeat (3 * 8 * SD) begin
      @(negedge clk_i);
      vecs++;
      if ({an_o, seg_o, dp_o} !== {exp_an, exp_seg, 1'b1}) begin
        errs++;
        $display("FAIL hex_scan t=%0t an=%h seg=%h dp=%b expected an=%h seg=%h", $time, an_o, seg_o, dp_o, exp_an, exp_seg);
      end
    end
  endtask
  task automatic test_decimal();
    data_i = 32'd12_345_678;
    layout_i = 4'h1;
    repeat (80) begin
      @(negedge clk_i);
      vecs++;
      if ({an_o, seg_o, dp_o} !== {exp_an, exp_seg, 1'b1}) begin
        errs++;
        $display("FAIL decimal t=%0t an=%h seg=%h dp=%b expected an=%h seg=%h", $time, an_o, seg_o, dp_o, exp_an, exp_seg);
      end
    end
  endtask
  task automatic test_overflow();
    for (int k = 0; k < 2; k++) begin
      data_i = (k == 0) ? 32'd100_000_000 : 32'd99_999_999;
      layout_i = 4'h1;
      repeat (75) begin
        @(negedge clk_i);
        vecs++;
        if ({an_o, seg_o, dp_o} !== {exp_an, exp_seg, 1'b1}) begin
          errs++;
          $display("FAIL overflow%0d t=%0t an=%h seg=%h dp=%b expected an=%h seg=%h", k, $time, an_o, seg_o, dp_o, exp_an, exp_seg);
        end
      end
    end
  endtask
  task automatic test_lzs();
    for (int k = 0; k < 2; k++) begin
      data_i = (k == 0) ? 32'hA5 : 32'h0;
      layout_i = 4'b0100;
      repeat (40) begin
        @(negedge clk_i);
        vecs++;
        if ({an_o, seg_o, dp_o} !== {exp_an, exp_seg, 1'b1}) begin
          errs++;
          $display("FAIL lzs%0d t=%0t an=%h seg=%h dp=%b expected an=%h seg=%h", k, $time, an_o, seg_o, dp_o, exp_an, exp_seg);
        end
      end
    end
  endtask
  task automatic test_blank();
    data_i = $urandom;
    for (int k = 0; k < 2; k++) begin
      layout_i = (k == 0) ? 4'b1000 : 4'b0000;
      repeat (25) begin
        @(negedge clk_i);
        vecs++;
        if ({an_o, seg_o, dp_o} !== {exp_an, exp_seg, 1'b1}) begin
          errs++;
          $display("FAIL blank%0d t=%0t an=%h seg=%h dp=%b expected an=%h seg=%h", k, $time, an_o, seg_o, dp_o, exp_an, exp_seg);
        end
      end
    end
  endtask
  task automatic test_conv_reset();
    data_i = 32'd12_345_678;
    layout_i = 4'h1;
    repeat (15) @(negedge clk_i);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    vecs++;
    if ({an_o, seg_o} !== {8'hFF, 7'h7F}) begin
      errs++;
      $display("FAIL conv_reset an=%h seg=%h expected an=ff seg=7f", an_o, seg_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (50) begin
      @(negedge clk_i);
      vecs++;
      if ({an_o, seg_o, dp_o} !== {exp_an, exp_seg, 1'b1}) begin
        errs++;
        $display("FAIL conv_reset_run t=%0t an=%h seg=%h dp=%b expected an=%h seg=%h", $time, an_o, seg_o, dp_o, exp_an, exp_seg);
      end
    end
  endtask
  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: data_i = $urandom;
        1: data_i = $urandom_range(0, 999);
        2: data_i = 32'd99_999_990 + $urandom_range(0, 20);
        default: data_i = '0;
      endcase
      layout_i = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 45)) begin
        @(negedge clk_i);
        vecs++;
        if ({an_o, seg_o, dp_o} !== {exp_an, exp_seg, 1'b1}) begin
          errs++;
          $display("FAIL random%0d t=%0t an=%h seg=%h dp=%b expected an=%h seg=%h", k, $time, an_o, seg_o, dp_o, exp_an, exp_seg);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_hex_scan();
    test_decimal();
    test_overflow();
    test_lzs();
    test_blank();
    test_conv_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
